r2sdf_butterfly_stage: RTL
==========================

# r2sdf_butterfly_stage

Parametrised radix-2 single-path delay-feedback (R2SDF) butterfly stage for the streaming FFT datapath. It accepts one complex sample per accepted cycle and pairs samples spaced DELAY apart through an internal feedback delay line. It emits the sums first, then the differences, each one bit wider than the input. Stages are chained with DELAY = N/2, N/4, …, 1, with twiddle multipliers between stages as separate blocks; lastIn/lastOut mark the end of a stream so the final differences are drained without further input.

## Interface
- DATA_WIDTH, 16, width of each real/imag input component (signed two's complement)
- DELAY, 4, butterfly span in samples; power of two, ≥ 1
- clkIn  in  1  clock; single clock domain
- rstIn  in  1  reset, synchronous, active-high
- enIn  in  1  global clock enable; no state or data register changes when low
- validIn  in  1  input sample valid; sample accepted when enIn && validIn
- lastIn  in  1  marks final sample of stream; honoured only on final sample of a BFLY half
- dataReIn, dataImIn  in  DATA_WIDTH each  signed input sample
- validOut  out  1  output sample valid, one-cycle pulse per output
- lastOut  out  1  high with the final drained output of a stream
- dataReOut, dataImOut  out  DATA_WIDTH+1 each  signed butterfly result

## Operation
- Inputs are sign-extended to DATA_WIDTH+1; all arithmetic is at DATA_WIDTH+1, with no rounding, scaling or saturation. Overflow is impossible by construction.
- Delay line: DELAY entries of complex DATA_WIDTH+1. It shifts by one on every advance event: an accepted sample, or an enIn cycle in DRAIN. head = oldest entry.
- Sample counter: log2(DELAY) bits; 0-bit when DELAY=1. primed flag records that the delay line holds differences.
- States and behaviour per advance event:
  - FILL: push extended input; emit head as output, valid only if primed. Count; on last count go to BFLY.
  - BFLY: emit head + in (valid); push head − in. On last count, set primed=1. Go to DRAIN if lastIn is high on this sample, else go to FILL.
  - DRAIN: each enIn cycle, validIn ignored, emit head (valid) and push zero. On last count set primed=0, pulse lastOut with this output, and go to FILL.
- Output order per block of 2·DELAY inputs a[0..D-1], b[0..D-1]: sums a[i]+b[i] for i=0..D-1, then differences a[i]−b[i] for i=0..D-1. The differences emerge during the next block's FILL, or during DRAIN.
- Complex re/im paths are independent and identical.
- lastIn is ignored in FILL and on non-final BFLY samples.
- validIn during DRAIN is a protocol violation; the sample is dropped and there is no error flag.

## Timing
- Reset: state FILL, counter 0, primed 0, delay line zeroed, validOut 0, lastOut 0, dataReOut/dataImOut 0. Reset mid-block discards all partial data; the first post-reset FILL emits no valid output.
- Output registers are loaded one clock after the advance event (latency 1). validOut/lastOut are updated every cycle and are low on any cycle whose previous cycle had no emitting event, including enIn=0 cycles.
- dataOut holds its last value when validOut=0.
- With enIn=0, all state, counter, delay line and data outputs hold.
- Sum for pair i appears 1 cycle after b[i] is accepted.
- Difference for pair i appears 1 cycle after the i-th FILL sample of the next block, or the i-th DRAIN cycle.
- Continuous input stream: one output per cycle after the first DELAY inputs.
- DELAY=1: states alternate each sample; DRAIN lasts exactly one cycle.
- Drain duration: DELAY enIn cycles; FILL is re-entered with primed=0.

## Test plan
- DELAY=4, W=16. Reset, then re inputs 1..8 back-to-back with lastIn on 8, im=0.
  - Required: re outputs 6,8,10,12 on the 4 cycles following inputs 5..8.
  - Then −4,−4,−4,−4 on the 4 drain cycles, lastOut on the final −4.
  - im outputs all 0.
- Two consecutive blocks 1..8 then 11..18, lastIn on 18.
  - Required: block-1 differences −4 ×4 appear 1 cycle after inputs 11..14.
  - Sums 26,28,30,32; then drain −4 ×4.
  - Exactly 16 validOut pulses in total.
- Extremes: a=−32768 and b=−32768 (re), a=32767 and b=−32768 (im).
  - Required: re sum −65536 and diff 0; im sum −1 and diff 65535. All fit in 17 bits.
- Scenario 1 with random enIn=0 and validIn=0 gaps.
  - Required: identical output value sequence and lastOut position.
  - No validOut pulse on any cycle following an enIn=0 cycle.
  - Outputs hold during gaps.
- Reset asserted after input 6 of scenario 1, then scenario 1 replayed.
  - Required: all outputs 0 and validOut 0 during reset.
  - Replay output is identical to scenario 1, with no stale values.
- DELAY=1: inputs 3,5 with lastIn on 5.
  - Required: output 8 (sum), then −2 with lastOut.
  - Also: with lastIn on a FILL sample, lastIn is ignored.

Source files
------------

// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly: pairs samples DELAY apart, emits sums then differences.
// Latency 1 cycle from advance event to output; no backpressure, enIn freezes all state.
module r2sdf_butterfly_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 4
) (
  input  logic                         clkIn,
  input  logic                         rstIn,
  input  logic                         enIn,
  input  logic                         validIn,
  input  logic                         lastIn,
  input  logic signed [DATA_WIDTH-1:0] dataReIn,
  input  logic signed [DATA_WIDTH-1:0] dataImIn,
  output logic                         validOut,
  output logic                         lastOut,
  output logic signed [DATA_WIDTH:0]   dataReOut,
  output logic signed [DATA_WIDTH:0]   dataImOut
);

  localparam int OW = DATA_WIDTH + 1;
  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 primed;
  logic signed [OW-1:0] lineRe [DELAY];
  logic signed [OW-1:0] lineIm [DELAY];

  logic signed [OW-1:0] inRe, inIm, headRe, headIm;
  logic signed [OW-1:0] pushRe, pushIm, outRe, outIm;
  logic                 emit, advance, lastCnt;

  assign inRe    = {dataReIn[DATA_WIDTH-1], dataReIn};
  assign inIm    = {dataImIn[DATA_WIDTH-1], dataImIn};
  assign headRe  = lineRe[0];
  assign headIm  = lineIm[0];
  // DRAIN advances on enIn alone so trailing differences leave without input
  assign advance = enIn && ((state == DRAIN) || validIn);
  assign lastCnt = (DELAY == 1) || (cnt == CW'(DELAY - 1));

  always_comb begin
    pushRe = inRe;
    pushIm = inIm;
    outRe  = headRe;
    outIm  = headIm;
    emit   = 1'b0;
    case (state)
      FILL: begin
        emit = primed;
      end
      BFLY: begin
        outRe  = headRe + inRe;
        outIm  = headIm + inIm;
        pushRe = headRe - inRe;
        pushIm = headIm - inIm;
        emit   = 1'b1;
      end
      DRAIN: begin
        pushRe = '0;
        pushIm = '0;
        emit   = 1'b1;
      end
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state     <= FILL;
      cnt       <= '0;
      primed    <= 1'b0;
      validOut  <= 1'b0;
      lastOut   <= 1'b0;
      dataReOut <= '0;
      dataImOut <= '0;
      for (int i = 0; i < DELAY; i++) begin
        lineRe[i] <= '0;
        lineIm[i] <= '0;
      end
    end else begin
      validOut <= advance && emit;
      lastOut  <= advance && (state == DRAIN) && lastCnt;
      if (advance) begin
        if (emit) begin
          dataReOut <= outRe;
          dataImOut <= outIm;
        end
        for (int i = 0; i < DELAY - 1; i++) begin
          lineRe[i] <= lineRe[i+1];
          lineIm[i] <= lineIm[i+1];
        end
        lineRe[DELAY-1] <= pushRe;
        lineIm[DELAY-1] <= pushIm;
        cnt <= lastCnt ? '0 : cnt + CW'(1);
        if (lastCnt) begin
          case (state)
            FILL:  state <= BFLY;
            BFLY: begin
              primed <= 1'b1;
              state  <= lastIn ? DRAIN : FILL;
            end
            DRAIN: begin
              primed <= 1'b0;
              state  <= FILL;
            end
            default: state <= FILL;
          endcase
        end
      end
    end
  end

endmodule
